// File: rtl/constants_pkg.sv
// Shared type definitions for the assembler datapath: the global assembly
// state and the line-transmission sub-state used by the sequencer.
package constants;

  // Global assembly run state, visible to the processor reset and status LED
  typedef enum logic [2:0] {
    IDLE,
    PC_MAPPING,
    INSTRUCTION_MAPPING,
    SUCCESS,
    ERROR
  } assembler_state_t;

  // Per-line transmission sub-state of the sequencer
  typedef enum logic [2:0] {
    OFF,
    START,
    NEW_LINE,
    SEND,
    DRAIN
  } tx_state_t;

endpackage

// File: rtl/assembler_sequencer_valid_delay_pipe.sv
// Fixed-depth shift pipe carrying a valid flag and its column index so the
// data-valid strobe lines up with the BRAM read latency. A synchronous squash
// discards everything in flight, including the value being shifted in.
module valid_delay_pipe #(
  parameter int DEPTH = 2,
  parameter int COL_W = 6
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             squash_in,
  input  logic             valid_in,
  input  logic [COL_W-1:0] col_in,
  output logic             valid_out,
  output logic [COL_W-1:0] col_out
);

  logic [DEPTH-1:0]            valid_q, valid_d;
  logic [DEPTH-1:0][COL_W-1:0] col_q, col_d;

  // Shift one stage per cycle, or empty the whole pipe on squash
  always_comb begin
    valid_d = '0;
    col_d   = '0;
    if (!squash_in) begin
      valid_d[0] = valid_in;
      col_d[0]   = col_in;
      for (int i = 1; i < DEPTH; i++) begin
        valid_d[i] = valid_q[i-1];
        col_d[i]   = col_q[i-1];
      end
    end
  end

  // Pipe stage registers with asynchronous clear
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      valid_q <= '0;
      col_q   <= '0;
    end else begin
      valid_q <= valid_d;
      col_q   <= col_d;
    end
  end

  assign valid_out = valid_q[DEPTH-1];
  assign col_out   = col_q[DEPTH-1];

endmodule

// File: rtl/assembler_sequencer.sv
// Two-pass assembly sequencer: walks the text-editor BRAM line by line,
// streams latency-aligned characters to the assembler and owns the global
// assembler state. Every output comes straight from a flop.
module assembler_sequencer
  import constants::*;
#(
  parameter int CHAR_PER_LINE = 64,
  parameter int NUMBER_LINES  = 256,
  parameter int READ_LATENCY  = 2
) (
  input  logic                                            clk_in,
  input  logic                                            rst_in,
  input  logic                                            start_in,
  input  logic                                            line_done_in,
  input  logic                                            line_error_in,
  output assembler_state_t                                state_out,
  output logic                                            asm_rst_out,
  output logic                                            rd_en_out,
  output logic [$clog2(CHAR_PER_LINE*NUMBER_LINES)-1:0]   rd_addr_out,
  output logic                                            new_line_out,
  output logic                                            new_char_out,
  output logic [$clog2(NUMBER_LINES)-1:0]                 line_count_out,
  output logic [$clog2(CHAR_PER_LINE)-1:0]                char_count_out,
  output logic                                            busy_out
);

  localparam int ADDR_W  = $clog2(CHAR_PER_LINE * NUMBER_LINES);
  localparam int LINE_W  = $clog2(NUMBER_LINES);
  localparam int COL_W   = $clog2(CHAR_PER_LINE);
  localparam int DRAIN_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;

  localparam logic [COL_W-1:0]   LAST_COL   = COL_W'(CHAR_PER_LINE - 1);
  localparam logic [LINE_W-1:0]  LAST_LINE  = LINE_W'(NUMBER_LINES - 1);
  localparam logic [DRAIN_W-1:0] LAST_DRAIN = DRAIN_W'(READ_LATENCY - 1);

  assembler_state_t    state_q, state_d;
  tx_state_t           tx_q, tx_d;
  logic [LINE_W-1:0]   line_q, line_d;
  logic [COL_W-1:0]    col_q, col_d;
  logic [DRAIN_W-1:0]  drain_q, drain_d;
  logic [ADDR_W-1:0]   rd_addr_q, rd_addr_d;
  logic [COL_W-1:0]    rd_col_q, rd_col_d;
  logic                asm_rst_q, asm_rst_d;
  logic                rd_en_q, rd_en_d;
  logic                new_line_q, new_line_d;
  logic                busy_q, busy_d;
  logic                squash;
  logic                line_end;
  logic                mapping;

  // Next-state logic: restart, error and early line end take priority over
  // the normal NEW_LINE -> SEND -> DRAIN walk; a finished line then decides
  // between the next line, the second pass and completion.
  always_comb begin
    state_d    = state_q;
    tx_d       = tx_q;
    line_d     = line_q;
    col_d      = col_q;
    drain_d    = drain_q;
    rd_addr_d  = rd_addr_q;
    rd_col_d   = rd_col_q;
    asm_rst_d  = 1'b0;
    rd_en_d    = 1'b0;
    new_line_d = 1'b0;
    squash     = 1'b0;
    line_end   = 1'b0;
    mapping    = (state_q == PC_MAPPING) || (state_q == INSTRUCTION_MAPPING);

    if (start_in) begin
      state_d   = PC_MAPPING;
      tx_d      = START;
      line_d    = '0;
      col_d     = '0;
      drain_d   = '0;
      squash    = 1'b1;
      asm_rst_d = 1'b1;
    end else if (mapping && line_error_in) begin
      state_d = ERROR;
      tx_d    = OFF;
      squash  = 1'b1;
    end else if (mapping && line_done_in && (tx_q == SEND || tx_q == DRAIN)) begin
      squash   = 1'b1;
      line_end = 1'b1;
    end else begin
      case (tx_q)
        START: begin
          tx_d  = NEW_LINE;
          col_d = '0;
        end
        NEW_LINE: begin
          new_line_d = 1'b1;
          tx_d       = SEND;
          col_d      = '0;
        end
        SEND: begin
          rd_en_d   = 1'b1;
          rd_addr_d = ADDR_W'(line_q) * ADDR_W'(CHAR_PER_LINE) + ADDR_W'(col_q);
          rd_col_d  = col_q;
          if (col_q == LAST_COL) begin
            tx_d    = DRAIN;
            drain_d = '0;
          end else begin
            col_d = col_q + 1'b1;
          end
        end
        DRAIN: begin
          if (drain_q == LAST_DRAIN) begin
            line_end = 1'b1;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end

    if (line_end) begin
      col_d   = '0;
      drain_d = '0;
      if (line_q != LAST_LINE) begin
        tx_d   = NEW_LINE;
        line_d = line_q + 1'b1;
      end else if (state_q == PC_MAPPING) begin
        state_d = INSTRUCTION_MAPPING;
        tx_d    = START;
        line_d  = '0;
      end else begin
        state_d = SUCCESS;
        tx_d    = OFF;
      end
    end

    busy_d = (state_d == PC_MAPPING) || (state_d == INSTRUCTION_MAPPING);
  end

  // State, counter and output registers
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q    <= IDLE;
      tx_q       <= OFF;
      line_q     <= '0;
      col_q      <= '0;
      drain_q    <= '0;
      rd_addr_q  <= '0;
      rd_col_q   <= '0;
      asm_rst_q  <= 1'b0;
      rd_en_q    <= 1'b0;
      new_line_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      tx_q       <= tx_d;
      line_q     <= line_d;
      col_q      <= col_d;
      drain_q    <= drain_d;
      rd_addr_q  <= rd_addr_d;
      rd_col_q   <= rd_col_d;
      asm_rst_q  <= asm_rst_d;
      rd_en_q    <= rd_en_d;
      new_line_q <= new_line_d;
      busy_q     <= busy_d;
    end
  end

  valid_delay_pipe #(
    .DEPTH (READ_LATENCY),
    .COL_W (COL_W)
  ) u_pipe (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .squash_in (squash),
    .valid_in  (rd_en_q),
    .col_in    (rd_col_q),
    .valid_out (new_char_out),
    .col_out   (char_count_out)
  );

  assign state_out      = state_q;
  assign asm_rst_out    = asm_rst_q;
  assign rd_en_out      = rd_en_q;
  assign rd_addr_out    = rd_addr_q;
  assign new_line_out   = new_line_q;
  assign line_count_out = line_q;
  assign busy_out       = busy_q;

endmodule

// File: tb/tb_assembler_sequencer.sv
// Directed bench for assembler_sequencer with W=4, H=2, READ_LATENCY=2.
module tb_assembler_sequencer;
  import constants::*;

  logic             clk_in;
  logic             rst_in;
  logic             start_in;
  logic             line_done_in;
  logic             line_error_in;
  assembler_state_t state_out;
  logic             asm_rst_out;
  logic             rd_en_out;
  logic [2:0]       rd_addr_out;
  logic             new_line_out;
  logic             new_char_out;
  logic [0:0]       line_count_out;
  logic [1:0]       char_count_out;
  logic             busy_out;

  int checkCount = 0;
  int errorCount = 0;

  assembler_sequencer #(
    .CHAR_PER_LINE (4),
    .NUMBER_LINES  (2),
    .READ_LATENCY  (2)
  ) dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .start_in       (start_in),
    .line_done_in   (line_done_in),
    .line_error_in  (line_error_in),
    .state_out      (state_out),
    .asm_rst_out    (asm_rst_out),
    .rd_en_out      (rd_en_out),
    .rd_addr_out    (rd_addr_out),
    .new_line_out   (new_line_out),
    .new_char_out   (new_char_out),
    .line_count_out (line_count_out),
    .char_count_out (char_count_out),
    .busy_out       (busy_out)
  );

  // Free-running 10-unit clock
  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic advance(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic applyStimulus(input bit s, input bit d, input bit e);
    start_in      = s;
    line_done_in  = d;
    line_error_in = e;
    tick();
    start_in      = 1'b0;
    line_done_in  = 1'b0;
    line_error_in = 1'b0;
  endtask

  task automatic applyReset();
    rst_in = 1'b1;
    advance(2);
    rst_in = 1'b0;
  endtask

  // Expected trace of a full two-pass run, cycle 0 = first cycle after start
  bit expRd[35];
  int expAddr[35];
  bit expNc[35];
  int expCc[35];
  bit expNl[35];
  int expLc[35];

  initial begin
    int a;
    bit found;
    assembler_state_t expState;

    start_in = 1'b0;
    line_done_in = 1'b0;
    line_error_in = 1'b0;
    rst_in = 1'b1;
    advance(2);
    rst_in = 1'b0;

    checkOutput("reset state", 32'(state_out), 32'(IDLE));
    checkOutput("reset rd_en", 32'(rd_en_out), 0);
    checkOutput("reset busy", 32'(busy_out), 0);

    // Asynchronous reset while a run is active, checked before any edge
    applyStimulus(1'b1, 1'b0, 1'b0);
    advance(4);
    checkOutput("pre-async busy", 32'(busy_out), 1);
    checkOutput("pre-async rd_en", 32'(rd_en_out), 1);
    #3;
    rst_in = 1'b1;
    #1;
    checkOutput("async state", 32'(state_out), 32'(IDLE));
    checkOutput("async rd_en", 32'(rd_en_out), 0);
    checkOutput("async rd_addr", 32'(rd_addr_out), 0);
    checkOutput("async busy", 32'(busy_out), 0);
    checkOutput("async new_char", 32'(new_char_out), 0);
    checkOutput("async asm_rst", 32'(asm_rst_out), 0);
    checkOutput("async line_count", 32'(line_count_out), 0);
    checkOutput("async char_count", 32'(char_count_out), 0);
    advance(2);
    rst_in = 1'b0;

    // Full run without line_done: two passes of two 7-cycle lines
    for (int p = 0; p < 2; p++) begin
      for (int l = 0; l < 2; l++) begin
        expNl[15*p + 2 + 7*l] = 1'b1;
        expLc[15*p + 2 + 7*l] = l;
        for (int col = 0; col < 4; col++) begin
          a = 15*p + 3 + 7*l + col;
          expRd[a]   = 1'b1;
          expAddr[a] = 4*l + col;
          expNc[a+2] = 1'b1;
          expCc[a+2] = col;
        end
      end
    end
    applyStimulus(1'b1, 1'b0, 1'b0);
    for (int c = 0; c < 35; c++) begin
      if (c < 15) expState = PC_MAPPING;
      else if (c < 30) expState = INSTRUCTION_MAPPING;
      else expState = SUCCESS;
      checkOutput($sformatf("run state c%0d", c), 32'(state_out), 32'(expState));
      checkOutput($sformatf("run busy c%0d", c), 32'(busy_out), (c < 30) ? 1 : 0);
      checkOutput($sformatf("run asm_rst c%0d", c), 32'(asm_rst_out), (c == 0) ? 1 : 0);
      checkOutput($sformatf("run rd_en c%0d", c), 32'(rd_en_out), 32'(expRd[c]));
      if (expRd[c]) checkOutput($sformatf("run rd_addr c%0d", c), 32'(rd_addr_out), expAddr[c]);
      checkOutput($sformatf("run new_char c%0d", c), 32'(new_char_out), 32'(expNc[c]));
      if (expNc[c]) checkOutput($sformatf("run char_count c%0d", c), 32'(char_count_out), expCc[c]);
      checkOutput($sformatf("run new_line c%0d", c), 32'(new_line_out), 32'(expNl[c]));
      if (expNl[c]) checkOutput($sformatf("run line_count c%0d", c), 32'(line_count_out), expLc[c]);
      tick();
    end

    // line_done while column 1 of line 0 is presented
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    advance(6);
    checkOutput("done new_char", 32'(new_char_out), 1);
    checkOutput("done char_count", 32'(char_count_out), 1);
    applyStimulus(1'b0, 1'b1, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 3 && !found; i++) begin
      checkOutput($sformatf("done squash %0d", i), 32'(new_char_out), 0);
      if (new_line_out) begin
        found = 1'b1;
        checkOutput("done line_count", 32'(line_count_out), 1);
      end else begin
        tick();
      end
    end
    checkOutput("done new_line seen", 32'(found), 1);
    tick();
    checkOutput("done next rd_en", 32'(rd_en_out), 1);
    checkOutput("done next rd_addr", 32'(rd_addr_out), 4);

    // line_error mid-SEND, then sticky ERROR, then restart
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    advance(4);
    checkOutput("err pre rd_addr", 32'(rd_addr_out), 1);
    applyStimulus(1'b0, 1'b0, 1'b1);
    checkOutput("err state", 32'(state_out), 32'(ERROR));
    checkOutput("err rd_en", 32'(rd_en_out), 0);
    checkOutput("err new_char", 32'(new_char_out), 0);
    checkOutput("err busy", 32'(busy_out), 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      checkOutput($sformatf("err quiet char %0d", i), 32'(new_char_out), 0);
      checkOutput($sformatf("err quiet rd_en %0d", i), 32'(rd_en_out), 0);
    end
    applyStimulus(1'b0, 1'b1, 1'b0);
    checkOutput("err sticky", 32'(state_out), 32'(ERROR));
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("err restart state", 32'(state_out), 32'(PC_MAPPING));
    checkOutput("err restart asm_rst", 32'(asm_rst_out), 1);

    // Restart during INSTRUCTION_MAPPING line 1
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    advance(26);
    checkOutput("rs pre state", 32'(state_out), 32'(INSTRUCTION_MAPPING));
    checkOutput("rs pre line", 32'(line_count_out), 1);
    checkOutput("rs pre rd_addr", 32'(rd_addr_out), 5);
    applyStimulus(1'b1, 1'b0, 1'b0);
    checkOutput("rs state", 32'(state_out), 32'(PC_MAPPING));
    checkOutput("rs line", 32'(line_count_out), 0);
    checkOutput("rs asm_rst", 32'(asm_rst_out), 1);
    checkOutput("rs rd_en", 32'(rd_en_out), 0);
    checkOutput("rs new_char c0", 32'(new_char_out), 0);
    tick();
    checkOutput("rs new_char c1", 32'(new_char_out), 0);
    checkOutput("rs asm_rst c1", 32'(asm_rst_out), 0);
    tick();
    checkOutput("rs new_char c2", 32'(new_char_out), 0);
    checkOutput("rs new_line c2", 32'(new_line_out), 1);
    checkOutput("rs line_count c2", 32'(line_count_out), 0);
    tick();
    checkOutput("rs rd_addr c3", 32'(rd_addr_out), 0);
    checkOutput("rs rd_en c3", 32'(rd_en_out), 1);

    // start and line_error together: start wins
    applyReset();
    applyStimulus(1'b1, 1'b0, 1'b0);
    advance(4);
    applyStimulus(1'b1, 1'b0, 1'b1);
    checkOutput("both state", 32'(state_out), 32'(PC_MAPPING));
    checkOutput("both asm_rst", 32'(asm_rst_out), 1);
    checkOutput("both busy", 32'(busy_out), 1);
    advance(2);
    checkOutput("both new_line", 32'(new_line_out), 1);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Guard against a hung run
  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
